cur_block_buffer: RTL and testbench

- Parametrised ping-pong buffer for current-frame blocks in the motion-estimation datapath.
- Accepts IN_PIX pixels per cycle into the write bank while the read bank feeds the SAD/PE array.
- On a swap, output rows move to the new block one row per cycle (systolic stagger), or all at once.
- Adds a valid/ready input handshake, a block-ready flag and early-swap error detection.

---
 rtl/me_pkg.sv | 27 ++
 rtl/cur_row_mux.sv | 27 ++
 rtl/cur_block_buffer.sv | 137 +++++++++++++
 tb/tb_cur_block_buffer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation datapath.
//   PIX_W_DEF               : pixel width in bits
//   BLK_W_DEF / BLK_H_DEF   : default block geometry in pixels
//   IN_PIX_DEF              : default pixels per input word
//   calc_wpr / calc_wpb     : input words per block row / per block
//   fill_state_e            : write-bank fill state (FILL, FULL)
package me_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int BLK_W_DEF  = 8;
  localparam int BLK_H_DEF  = 8;
  localparam int IN_PIX_DEF = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  function automatic int calc_wpr(input int blk_w, input int in_pix);
    return blk_w / in_pix;
  endfunction

  function automatic int calc_wpb(input int blk_w, input int blk_h, input int in_pix);
    return calc_wpr(blk_w, in_pix) * blk_h;
  endfunction

endpackage

// File: rtl/cur_row_mux.sv
// Bank select for one output row of the current-block buffer.
//   bank0_row, bank1_row : this row's pixels in bank 0 / bank 1
//   rd_bank              : bank currently being read (already the new bank during a stagger)
//   sc                   : stagger counter; holds BLK_H-1 when no stagger is in progress
//   row                  : pixels presented on cur_out for this row
module cur_row_mux #(
  parameter int ROW_BITS = 64,
  parameter int ROW_IDX  = 0,
  parameter int SC_W     = 3
) (
  input  logic [ROW_BITS-1:0] bank0_row,
  input  logic [ROW_BITS-1:0] bank1_row,
  input  logic                rd_bank,
  input  logic [SC_W-1:0]     sc,
  output logic [ROW_BITS-1:0] row
);

  logic sel;

  // A row has switched once the stagger counter has reached its index;
  // until then it keeps showing the previous read bank (~rd_bank).
  always_comb begin
    sel = (int'(sc) >= ROW_IDX) ? rd_bank : ~rd_bank;
    row = sel ? bank1_row : bank0_row;
  end

endmodule

// File: rtl/cur_block_buffer.sv
// Ping-pong buffer for current-frame blocks feeding the SAD/PE array.
// One bank is filled from cur_in while the other is presented on cur_out.
// On a swap the output rows move to the new bank either one row per cycle
// (STAGGER=1) or all at once (STAGGER=0).
//   clk, rst    : clock, synchronous active-high reset
//   next_block  : single-cycle swap request (honoured only when the write bank is full)
//   cur_valid   : cur_in holds a valid word
//   cur_in      : IN_PIX pixels in raster order, lowest pixel in the LSBs
//   need_cur    : ready; a word is taken when cur_valid && need_cur
//   cur_out     : whole read block, row r at bits [(r+1)*BLK_W*PIX_W-1 : r*BLK_W*PIX_W]
//   blk_ready   : write bank completely filled
//   swap_busy   : row stagger in progress
//   swap_err    : one-cycle pulse after next_block arrived while still filling
module cur_block_buffer
  import me_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int BLK_W   = BLK_W_DEF,
  parameter int BLK_H   = BLK_H_DEF,
  parameter int IN_PIX  = IN_PIX_DEF,
  parameter int STAGGER = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         next_block,
  input  logic                         cur_valid,
  input  logic [IN_PIX*PIX_W-1:0]      cur_in,
  output logic                         need_cur,
  output logic [BLK_W*BLK_H*PIX_W-1:0] cur_out,
  output logic                         blk_ready,
  output logic                         swap_busy,
  output logic                         swap_err
);

  localparam int WPR       = calc_wpr(BLK_W, IN_PIX);
  localparam int WPB       = calc_wpb(BLK_W, BLK_H, IN_PIX);
  localparam int ROW_BITS  = BLK_W * PIX_W;
  localparam int BLK_BITS  = ROW_BITS * BLK_H;
  localparam int WORD_BITS = IN_PIX * PIX_W;
  localparam int WIDX_W    = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int SC_W      = (BLK_H > 1) ? $clog2(BLK_H) : 1;

  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WPB - 1);
  localparam logic [SC_W-1:0]   SC_IDLE   = SC_W'(BLK_H - 1);

  // The refill of the old bank must never overtake the row stagger, and
  // words must tile rows exactly.
  if (BLK_W % IN_PIX != 0) begin : g_chk_tile
    $error("cur_block_buffer: BLK_W must be a multiple of IN_PIX");
  end
  if (WPB < BLK_H * STAGGER) begin : g_chk_stagger
    $error("cur_block_buffer: block fill is shorter than the row stagger");
  end
  if (WPR < 1) begin : g_chk_wpr
    $error("cur_block_buffer: IN_PIX wider than a block row");
  end

  logic [1:0][BLK_BITS-1:0] bank_q;
  logic                     rd_bank_q;
  logic [WIDX_W-1:0]        widx_q;
  fill_state_e              state_q;
  fill_state_e              state_d;
  logic [SC_W-1:0]          sc_q;
  logic                     swap_err_q;

  logic accept;
  logic last_word;
  logic swap_ok;

  // NOTE: every signal driven here gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    need_cur  = (state_q == FILL);
    blk_ready = (state_q == FULL);
    accept    = need_cur && cur_valid;
    last_word = accept && (widx_q == WIDX_LAST);
    // The swap is judged on the state at the edge, so a last word and a
    // swap request in the same cycle is still an early swap.
    swap_ok   = next_block && (state_q == FULL);
    case (state_q)
      FILL:    if (last_word) state_d = FULL;
      FULL:    if (swap_ok)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank storage is reset too, because the output must read
      // as zeros until the first block has been swapped in.
      bank_q     <= '0;
      rd_bank_q  <= 1'b0;
      widx_q     <= '0;
      state_q    <= FILL;
      sc_q       <= SC_IDLE;
      swap_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      swap_err_q <= next_block && (state_q == FILL);

      if (accept) begin
        bank_q[~rd_bank_q][int'(widx_q)*WORD_BITS +: WORD_BITS] <= cur_in;
        widx_q <= last_word ? '0 : widx_q + 1'b1;
      end

      // sc counts the rows already switched; it saturates at SC_IDLE, which
      // doubles as "no stagger in progress".
      if (swap_ok) begin
        rd_bank_q <= ~rd_bank_q;
        if (STAGGER != 0) sc_q <= '0;
      end else if (sc_q != SC_IDLE) begin
        sc_q <= sc_q + 1'b1;
      end
    end
  end

  assign swap_busy = (sc_q != SC_IDLE);
  assign swap_err  = swap_err_q;

  for (genvar r = 0; r < BLK_H; r++) begin : g_row
    cur_row_mux #(
      .ROW_BITS (ROW_BITS),
      .ROW_IDX  (r),
      .SC_W     (SC_W)
    ) u_row_mux (
      .bank0_row (bank_q[0][r*ROW_BITS +: ROW_BITS]),
      .bank1_row (bank_q[1][r*ROW_BITS +: ROW_BITS]),
      .rd_bank   (rd_bank_q),
      .sc        (sc_q),
      .row       (cur_out[r*ROW_BITS +: ROW_BITS])
    );
  end

endmodule

// File: tb/tb_cur_block_buffer.sv
// Self-checking bench for cur_block_buffer: a default staggered instance
// (8x8 block, 4 pixels/word) and an all-at-once instance (8 pixels/word).
module tb_cur_block_buffer;

  localparam int PIX_W    = 8;
  localparam int BLK_W    = 8;
  localparam int BLK_H    = 8;
  localparam int ROW_BITS = BLK_W * PIX_W;
  localparam int BLK_BITS = ROW_BITS * BLK_H;
  localparam int WPB      = 16;
  localparam int WPB2     = 8;
  localparam int ZERO     = -1;  // block base meaning "all pixels zero"

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Staggered instance
  logic                next_block, cur_valid;
  logic [31:0]         cur_in;
  logic                need_cur, blk_ready, swap_busy, swap_err;
  logic [BLK_BITS-1:0] cur_out;

  // All-at-once instance
  logic                next_block2, cur_valid2;
  logic [63:0]         cur_in2;
  logic                need_cur2, blk_ready2, swap_busy2, swap_err2;
  logic [BLK_BITS-1:0] cur_out2;

  cur_block_buffer #(
    .PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .IN_PIX(4), .STAGGER(1)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .next_block (next_block),
    .cur_valid  (cur_valid),
    .cur_in     (cur_in),
    .need_cur   (need_cur),
    .cur_out    (cur_out),
    .blk_ready  (blk_ready),
    .swap_busy  (swap_busy),
    .swap_err   (swap_err)
  );

  cur_block_buffer #(
    .PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .IN_PIX(8), .STAGGER(0)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .next_block (next_block2),
    .cur_valid  (cur_valid2),
    .cur_in     (cur_in2),
    .need_cur   (need_cur2),
    .cur_out    (cur_out2),
    .blk_ready  (blk_ready2),
    .swap_busy  (swap_busy2),
    .swap_err   (swap_err2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        exp_need;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Test blocks: pixel p (raster index 0..63) holds base+p.
  function automatic logic [31:0] word_of(input int base, input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(base + 4*k + j);
    return w;
  endfunction

  function automatic logic [63:0] word2_of(input int base, input int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(base + 8*k + j);
    return w;
  endfunction

  function automatic logic [63:0] row_of(input int base, input int r);
    logic [63:0] v;
    v = '0;
    if (base != ZERO)
      for (int c = 0; c < BLK_W; c++) v[c*8 +: 8] = 8'(base + BLK_W*r + c);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rows below n_new show new_b, the rest old_b.
  task automatic check_rows(input string name, input int old_b, input int new_b, input int n_new);
    for (int r = 0; r < BLK_H; r++)
      check($sformatf("%s row%0d", name, r), cur_out[r*ROW_BITS +: ROW_BITS],
            (r < n_new) ? row_of(new_b, r) : row_of(old_b, r));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " need_cur"},  need_cur,  1'b1);
    check({name, " blk_ready"}, blk_ready, 1'b0);
    check({name, " swap_busy"}, swap_busy, 1'b0);
    check({name, " swap_err"},  swap_err,  1'b0);
    check_rows({name, " cur_out"}, ZERO, ZERO, 0);
  endtask

  task automatic fill_words(input int base, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      check($sformatf("need_cur word%0d", k), need_cur, 1'b1);
      cur_valid = 1'b1;
      cur_in    = word_of(base, k);
      tick();
    end
    cur_valid = 1'b0;
    cur_in    = '0;
  endtask

  // Pulse a swap, then follow the stagger cycle by cycle while optionally
  // refilling the old read bank at full rate.
  task automatic swap_fill(input int old_b, input int new_b, input int fill_b, input bit do_fill);
    next_block = 1'b1;
    tick();
    next_block = 1'b0;
    for (int i = 0; i < WPB; i++) begin
      if (i < BLK_H) begin
        check_rows($sformatf("stagger c%0d", i + 1), old_b, new_b, i + 1);
        check($sformatf("swap_busy c%0d", i + 1), swap_busy, (i < BLK_H - 1));
      end
      if (do_fill) begin
        check($sformatf("refill need_cur w%0d", i), need_cur, 1'b1);
        cur_valid = 1'b1;
        cur_in    = word_of(fill_b, i);
      end
      tick();
    end
    cur_valid = 1'b0;
    cur_in    = '0;
    check("blk_ready after swap", blk_ready, do_fill);
  endtask

  initial begin
    rst = 1'b1;
    next_block = 1'b0; cur_valid = 1'b0; cur_in = '0;
    next_block2 = 1'b0; cur_valid2 = 1'b0; cur_in2 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_idle_outputs("reset");

    // Block A (base 0): words 0x03020100 + 0x04040404*k
    fill_words(0, 0, WPB - 1);
    check("need_cur before last word", need_cur, 1'b1);
    check("blk_ready before last word", blk_ready, 1'b0);
    fill_words(0, WPB - 1, 1);
    check("need_cur after fill", need_cur, 1'b0);
    check("blk_ready after fill", blk_ready, 1'b1);
    check_rows("after first fill", ZERO, ZERO, 0);

    // Swap to A while refilling with B; old rows are bank0 zeros.
    swap_fill(ZERO, 0, 128, 1'b1);
    // Swap to B while refilling A's bank with C; old rows must keep A.
    swap_fill(0, 128, 64, 1'b1);
    // Swap to C without refilling.
    swap_fill(128, 64, 0, 1'b0);

    // Early swap after 10 words of D.
    fill_words(160, 0, 10);
    next_block = 1'b1;
    tick();
    next_block = 1'b0;
    check("early swap_err", swap_err, 1'b1);
    check("early need_cur", need_cur, 1'b1);
    check("early blk_ready", blk_ready, 1'b0);
    check_rows("early no swap", 64, 64, BLK_H);
    tick();
    check("early swap_err cleared", swap_err, 1'b0);
    check("early swap_busy", swap_busy, 1'b0);
    fill_words(160, 10, 5);
    // Last word together with next_block: still an early swap.
    check("need_cur last D word", need_cur, 1'b1);
    next_block = 1'b1;
    cur_valid  = 1'b1;
    cur_in     = word_of(160, 15);
    tick();
    next_block = 1'b0;
    cur_valid  = 1'b0;
    cur_in     = '0;
    check("last-word swap_err", swap_err, 1'b1);
    check("last-word blk_ready", blk_ready, 1'b1);
    check("last-word need_cur", need_cur, 1'b0);
    check_rows("last-word no swap", 64, 64, BLK_H);
    tick();
    check("last-word swap_err cleared", swap_err, 1'b0);
    swap_fill(64, 160, 0, 1'b0);

    // Block E with cur_valid toggling; invalid cycles carry junk.
    for (int i = 0; i < 32; i++) begin
      vecs[i].valid     = (i % 2 == 0);
      vecs[i].data      = vecs[i].valid ? word_of(224, i / 2) : 32'hDEAD_BEEF;
      vecs[i].exp_need  = (i < 30);
      vecs[i].exp_ready = (i >= 30);
    end
    for (int i = 0; i < 32; i++) begin
      cur_valid = vecs[i].valid;
      cur_in    = vecs[i].data;
      tick();
      check($sformatf("toggle need_cur v%0d", i), need_cur, vecs[i].exp_need);
      check($sformatf("toggle blk_ready v%0d", i), blk_ready, vecs[i].exp_ready);
    end
    cur_valid = 1'b0;
    cur_in    = '0;
    swap_fill(160, 224, 0, 1'b0);

    // Reset after 7 words of a partial fill, then a fresh fill.
    fill_words(0, 0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid-fill reset");
    fill_words(96, 0, WPB);
    check("post-reset blk_ready", blk_ready, 1'b1);
    swap_fill(ZERO, 96, 0, 1'b0);

    // All-at-once instance, 8 words of 64 bits.
    for (int k = 0; k < WPB2; k++) begin
      check($sformatf("dut2 need_cur w%0d", k), need_cur2, 1'b1);
      cur_valid2 = 1'b1;
      cur_in2    = word2_of(32, k);
      tick();
    end
    cur_valid2 = 1'b0;
    cur_in2    = '0;
    check("dut2 need_cur full", need_cur2, 1'b0);
    check("dut2 blk_ready full", blk_ready2, 1'b1);
    check("dut2 row0 before swap", cur_out2[0 +: ROW_BITS], row_of(ZERO, 0));
    next_block2 = 1'b1;
    tick();
    next_block2 = 1'b0;
    for (int r = 0; r < BLK_H; r++)
      check($sformatf("dut2 row%0d at E+1", r), cur_out2[r*ROW_BITS +: ROW_BITS], row_of(32, r));
    for (int i = 0; i < BLK_H; i++) begin
      check($sformatf("dut2 swap_busy c%0d", i + 1), swap_busy2, 1'b0);
      tick();
    end
    check("dut2 need_cur after swap", need_cur2, 1'b1);
    check("dut2 swap_err", swap_err2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
